// File: rtl/crack_pkg.sv
// crack_pkg: shared width default, dispatch state type and lowest-set-bit helper
package crack_pkg;
   localparam int KEY_W_DEFAULT = 24;
   typedef enum logic [2:0] {IDLE, LAUNCH, SYNC, RUN, ABORT, DONE} state_e;
   function automatic int lowest_set(input logic [15:0] v);
      lowest_set = 0;
      for (int i = 15; i >= 0; i--) if (v[i]) lowest_set = i;
   endfunction
endpackage

// File: rtl/crack_prio_enc.sv
// crack_prio_enc: lowest-index-wins priority encoder, one-hot and binary results
module crack_prio_enc import crack_pkg::*; #(
   parameter int N = 2,
   parameter int IDX_W = 1
) (
   input  logic [N-1:0]     req_i,
   output logic             any_o,
   output logic [N-1:0]     onehot_o,
   output logic [IDX_W-1:0] idx_o
);
   assign any_o = |req_i;
   assign onehot_o = req_i & (~req_i + N'(1));
   assign idx_o = IDX_W'(lowest_set(16'(req_i)));
endmodule

// File: rtl/crack_dispatch.sv
// crack_dispatch: interleaved multi-core key search dispatcher; CRACK_DISPATCH_CYCLE_COUNT_EN adds a cycles counter
module crack_dispatch import crack_pkg::*; #(
   parameter int N_CORES = 2,
   parameter int KEY_W = KEY_W_DEFAULT,
   parameter int IDX_W = (N_CORES > 1) ? $clog2(N_CORES) : 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     en,
   output logic                     rdy,
   output logic [KEY_W-1:0]         key,
   output logic                     key_valid,
   output logic [IDX_W-1:0]         winner,
   output logic [N_CORES-1:0]       core_en,
   input  logic [N_CORES-1:0]       core_rdy,
   input  logic [N_CORES*KEY_W-1:0] core_key,
   input  logic [N_CORES-1:0]       core_key_valid,
   output logic [N_CORES*KEY_W-1:0] core_base,
   output logic [KEY_W-1:0]         core_stride,
   output logic                     core_abort
`ifdef CRACK_DISPATCH_CYCLE_COUNT_EN
   ,
   output logic [31:0]              cycles
`endif
);
   state_e state_q, state_d;
   logic [N_CORES-1:0] done_q, done_d, hit_oh;
   logic [KEY_W-1:0] key_q, key_d, hit_key;
   logic key_valid_q, key_valid_d, any_hit, all_done, rst_abort_q, start;
   logic [IDX_W-1:0] winner_q, winner_d, hit_idx;
   for (genvar g = 0; g < N_CORES; g++) begin : g_base
      assign core_base[g*KEY_W +: KEY_W] = KEY_W'(g);
   end
   assign core_stride = KEY_W'(N_CORES);
   crack_prio_enc #(.N(N_CORES), .IDX_W(IDX_W)) u_prio (
      .req_i    (core_rdy & core_key_valid),
      .any_o    (any_hit),
      .onehot_o (hit_oh),
      .idx_o    (hit_idx)
   );
   always_comb begin
      hit_key = '0;
      for (int i = 0; i < N_CORES; i++) hit_key |= hit_oh[i] ? core_key[i*KEY_W +: KEY_W] : '0;
   end
   assign all_done = &(done_q | core_rdy);
   assign start = rdy && en;
   always_ff @(posedge clk) state_q <= rst ? IDLE : state_d;
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE, DONE: state_d = en ? LAUNCH : IDLE;
         LAUNCH:     state_d = SYNC;
         SYNC:       state_d = (core_rdy == '0) ? RUN : SYNC;
         RUN:        state_d = any_hit ? ABORT : all_done ? DONE : RUN;
         ABORT:      state_d = DONE;
         default:    state_d = IDLE;
      endcase
   end
   always_comb begin
      rdy = (state_q == IDLE) || (state_q == DONE);
      core_en = {N_CORES{state_q == LAUNCH}};
      core_abort = rst_abort_q || (state_q == ABORT);
   end
   always_comb begin
      done_d = start ? '0 : (state_q == RUN) ? (done_q | core_rdy) : done_q;
      key_d = key_q;
      key_valid_d = key_valid_q;
      winner_d = winner_q;
      if (state_q == RUN && any_hit) begin
         key_d = hit_key;
         key_valid_d = 1'b1;
         winner_d = hit_idx;
      end else if (state_q == RUN && all_done) begin
         key_d = '0;
         key_valid_d = 1'b0;
         winner_d = '0;
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         done_q <= '0;
         key_q <= '0;
         key_valid_q <= 1'b0;
         winner_q <= '0;
         rst_abort_q <= 1'b1;
      end else begin
         done_q <= done_d;
         key_q <= key_d;
         key_valid_q <= key_valid_d;
         winner_q <= winner_d;
         rst_abort_q <= 1'b0;
      end
   end
   assign key = key_q;
   assign key_valid = key_valid_q;
   assign winner = winner_q;
`ifdef CRACK_DISPATCH_CYCLE_COUNT_EN
   logic [31:0] cycles_q, cycles_d;
   always_comb cycles_d = start ? '0 : ((state_q == SYNC || state_q == RUN) && cycles_q != '1) ? cycles_q + 32'd1 : cycles_q;
   always_ff @(posedge clk) cycles_q <= rst ? '0 : cycles_d;
   assign cycles = cycles_q;
`endif
endmodule

// File: tb/tb_crack_dispatch.sv
// tb_crack_dispatch: scoreboard bench for crack_dispatch with four cores
module tb_crack_dispatch;
   logic clk = 0, rst = 1, en = 0;
   logic rdy, key_valid, core_abort;
   logic [23:0] key, core_stride;
   logic [1:0] winner;
   logic [3:0] core_en, core_rdy = 4'hf, core_key_valid = 0;
   logic [95:0] core_key = 0, core_base;
`ifdef CRACK_DISPATCH_CYCLE_COUNT_EN
   logic [31:0] cycles;
`endif
   int n_chk = 0, n_fail = 0;
   typedef struct {logic [23:0] key; logic kv; logic [1:0] win; int ab;} exp_t;
   exp_t sb[$];
   crack_dispatch #(.N_CORES(4), .KEY_W(24)) dut (
      .clk(clk), .rst(rst), .en(en), .rdy(rdy), .key(key), .key_valid(key_valid),
      .winner(winner), .core_en(core_en), .core_rdy(core_rdy), .core_key(core_key),
      .core_key_valid(core_key_valid), .core_base(core_base), .core_stride(core_stride),
      .core_abort(core_abort)
`ifdef CRACK_DISPATCH_CYCLE_COUNT_EN
      , .cycles(cycles)
`endif
   );
   always #5 clk = ~clk;
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask
   task automatic launch(input int n_stale);
      en = 1;
      cyc();
      en = 0;
      chk("core_en_pulse", 32'(core_en), 32'hf);
      chk("rdy_busy", 32'(rdy), 0);
      cyc();
      chk("core_en_once", 32'(core_en), 0);
      repeat (n_stale) begin
         cyc();
         chk("sync_ignores_stale", 32'(rdy), 0);
      end
      core_rdy = 0;
      cyc();
   endtask
   task automatic wait_rdy(input int lat);
      int k = 0;
      do begin
         cyc();
         k++;
      end while (!rdy && k < 10);
      chk("latency", k, lat);
      core_rdy = 4'hf;
      core_key_valid = 0;
   endtask
   task automatic finish_core(input int c, input logic v, input logic [23:0] k);
      core_rdy[c] = 1;
      core_key_valid[c] = v;
      core_key[c*24 +: 24] = k;
   endtask
   initial begin : monitor
      logic prev_rdy = 1;
      int ab_cnt = 0;
      exp_t e;
      forever begin
         @(negedge clk);
         if (prev_rdy && !rdy) ab_cnt = 0;
         if (core_abort) ab_cnt++;
         if (!prev_rdy && rdy) begin
            if (sb.size() == 0) begin
               chk("unexpected_result", 1, 0);
            end else begin
               e = sb.pop_front();
               chk("key", 32'(key), 32'(e.key));
               chk("key_valid", 32'(key_valid), 32'(e.kv));
               if (e.kv) chk("winner", 32'(winner), 32'(e.win));
               chk("abort_pulses", ab_cnt, e.ab);
            end
         end
         prev_rdy = rdy;
      end
   end
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
   initial begin
      cyc();
      rst = 0;
      chk("rst_rdy", 32'(rdy), 1);
      chk("rst_key_valid", 32'(key_valid), 0);
      chk("rst_key", 32'(key), 0);
      chk("rst_winner", 32'(winner), 0);
      chk("rst_core_en", 32'(core_en), 0);
      chk("rst_abort", 32'(core_abort), 1);
      cyc();
      chk("rst_abort_once", 32'(core_abort), 0);
      chk("base2", 32'(core_base[48 +: 24]), 2);
      chk("base3", 32'(core_base[72 +: 24]), 3);
      chk("stride", 32'(core_stride), 4);
      // single hit on core 2, with stale core_rdy held through SYNC
      sb.push_back('{24'h00001a, 1'b1, 2'd2, 1});
      launch(2);
      repeat (3) cyc();
      finish_core(2, 1, 24'h00001a);
      wait_rdy(2);
      // simultaneous hits; en during RUN is ignored
      sb.push_back('{24'h000005, 1'b1, 2'd1, 1});
      launch(0);
      en = 1;
      cyc();
      en = 0;
      chk("en_busy_ignored", 32'(core_en), 0);
      cyc();
      finish_core(1, 1, 24'h000005);
      finish_core(3, 1, 24'h000007);
      wait_rdy(2);
      // staggered exhaustion
      sb.push_back('{24'h0, 1'b0, 2'd0, 0});
      launch(0);
      finish_core(0, 0, 24'h111111);
      cyc();
      finish_core(2, 0, 24'h222222);
      cyc();
      finish_core(1, 0, 24'h333333);
      cyc();
      chk("not_done_early", 32'(rdy), 0);
      finish_core(3, 0, 24'h444444);
      wait_rdy(1);
      // hit coincides with the last completion
      sb.push_back('{24'h000033, 1'b1, 2'd2, 1});
      launch(0);
      finish_core(0, 0, 24'h0);
      cyc();
      finish_core(1, 0, 24'h0);
      finish_core(3, 0, 24'h0);
      cyc();
      finish_core(2, 1, 24'h000033);
      wait_rdy(2);
      // reset during RUN
      sb.push_back('{24'h0, 1'b0, 2'd0, 1});
      launch(0);
      repeat (2) cyc();
      rst = 1;
      cyc();
      rst = 0;
      chk("midrst_rdy", 32'(rdy), 1);
      chk("midrst_abort", 32'(core_abort), 1);
      core_rdy = 4'hf;
      cyc();
`ifdef CRACK_DISPATCH_CYCLE_COUNT_EN
      sb.push_back('{24'h0000aa, 1'b1, 2'd0, 1});
      launch(1);
      repeat (99) cyc();
      finish_core(0, 1, 24'h0000aa);
      wait_rdy(2);
      chk("cycles", cycles, 102);
      cyc();
      chk("cycles_hold", cycles, 102);
`endif
      repeat (3) cyc();
      chk("scoreboard_empty", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/crack_dispatch.md
Name: crack_dispatch

Overview:
- Parametrised successor to the single-core ARC4 key-search top level.
- Launches N_CORES crack cores in parallel. Each core searches an interleaved slice of the KEY_W-bit key space: core i tries keys i, i+N_CORES, i+2*N_CORES, ...
- Collects the first valid key, aborts the remaining cores, and presents key, key_valid and winning core index upstream through the same en/rdy handshake the crack core uses.
- Sits between the board top level (HEX/LEDR display) and the crack core array.

Parameters:
- N_CORES, 2, number of crack cores; legal range 1..16.
- KEY_W, 24, key width in bits.
- IDX_W, $clog2(N_CORES) with minimum 1, width of the winner index.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- en  in  1  start request; sampled only while rdy=1.
- rdy  out  1  high when idle and able to accept en.
- key  out  KEY_W  winning key; valid when rdy=1 and key_valid=1.
- key_valid  out  1  1 = key found; 0 = key space exhausted with no hit.
- winner  out  IDX_W  index of the winning core.
- core_en  out  N_CORES  one-cycle start pulse per core.
- core_rdy  in  N_CORES  per-core idle/finished flag.
- core_key  in  N_CORES*KEY_W  per-core result key; slice i = bits [i*KEY_W +: KEY_W].
- core_key_valid  in  N_CORES  per-core hit flag; meaningful only while core_rdy[i]=1.
- core_base  out  N_CORES*KEY_W  starting key per core; constant, slice i = i.
- core_stride  out  KEY_W  key increment; constant = N_CORES.
- core_abort  out  1  synchronous kill to all cores, active-high, one cycle.

Behaviour:
- States: IDLE, LAUNCH, SYNC, RUN, ABORT, DONE.
- Reset (rst=1 on a clock edge) forces:
  - state=IDLE, rdy=1, key=0, key_valid=0, winner=0
  - core_en=0, core_abort=1 for that cycle, done_mask=0.
- Reset mid-search is legal: everything returns to IDLE on the next edge and cores are killed via core_abort.
- IDLE:
  - rdy=1.
  - When en=1: clear done_mask, go to LAUNCH; rdy=0 from the next cycle.
  - key and key_valid hold their previous result until the new launch.
- LAUNCH: core_en = all ones for exactly one cycle, then go to SYNC.
- SYNC:
  - Wait until core_rdy == 0 (every core has acknowledged the start).
  - Then go to RUN.
  - This blocks a stale core_rdy from being taken as completion.
- RUN, every cycle:
  - done_mask |= core_rdy.
  - hits = core_rdy & core_key_valid.
  - If hits != 0: winner = lowest set index, key = that core's core_key, key_valid=1, go to ABORT.
  - Simultaneous hits on the same cycle: the lowest index wins, deterministically.
  - Else if (done_mask | core_rdy) == all ones: key_valid=0, key=0, go to DONE.
  - A hit and the last completion on the same cycle count as a hit.
- ABORT: core_abort=1 for one cycle, then go to DONE.
- DONE: rdy=1, outputs stable, go to IDLE on the same edge, so DONE behaves as IDLE with a fresh result.
- en while rdy=0: ignored, with no queuing.
- Latency:
  - en to core_en: 1 cycle.
  - Winning core_rdy to rdy=1: 2 cycles on a hit, 1 cycle on exhaustion.
- N_CORES=1 degenerates to the single-core flow: winner always 0, stride 1.

Optional Feature:
- Macro: CRACK_DISPATCH_CYCLE_COUNT_EN.
- Defined:
  - Adds output port cycles (32 bits).
  - Counter clears on the LAUNCH entry and increments each cycle in SYNC/RUN.
  - Saturates at 0xFFFFFFFF.
  - Holds its value in DONE/IDLE; reset value 0.
- Undefined: port and counter are absent; behaviour otherwise identical.

Decomposition:
- Package crack_pkg holds:
  - KEY_W_DEFAULT = 24
  - the dispatch state enum type
  - a function that returns the lowest set bit index of a vector.
- One sub-module: crack_prio_enc (parametrised priority encoder over N_CORES).
  - Outputs any_hit and a one-hot/index result.
  - Used to select the winner and mux core_key.

Test Plan:
- Reset then idle: rst pulse -> rdy=1, key_valid=0, core_abort=1 for 1 cycle, core_en=0.
- Single hit, N_CORES=4: en, hold core_rdy=0, then core 2 raises core_rdy with core_key_valid=1 and key 0x00001A -> key=0x00001A, winner=2, key_valid=1, core_abort pulses once, rdy=1 two cycles later.
- Simultaneous hits: cores 1 and 3 hit on the same cycle with keys 0x000005 and 0x000007 -> winner=1, key=0x000005.
- Exhaustion: all cores finish at staggered cycles with key_valid=0 -> key_valid=0, key=0, no core_abort, rdy=1 one cycle after the last core_rdy.
- Protocol: en asserted while busy is ignored; stale core_rdy=1 during SYNC does not end the search; rst mid-RUN returns to IDLE with core_abort asserted.
- Macro build: launch, SYNC for 2 cycles, hit after 100 RUN cycles -> cycles=102 held in DONE.
